packet_deparser: RTL and testbench

Builds an Ethernet II header (optional 802.1Q tag), an IPv4 header and a TCP/UDP header from discrete field inputs. It streams the header out one byte per cycle over a valid/ready interface. It sits on the egress side of the DataPlane and mirrors packet_parser_gold: fields that the parser extracts are the fields this block emits. The IPv4 header checksum is computed in hardware before streaming starts.

---
 rtl/deparser_pkg.sv | 33 +++
 rtl/ipv4_csum_acc.sv | 30 +++
 rtl/packet_deparser.sv | 229 ++++++++++++++++++++++
 tb/tb_packet_deparser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deparser_pkg.sv
// Shared types and constants for the packet deparser: FSM encoding, Ethertypes, IP protocols, header lengths.
package deparser_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CSUM   = 3'd1,
    S_FOLD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] TPID_VLAN     = 16'h8100;

  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;

  localparam logic [6:0] ETH_HDR_LEN  = 7'd14;
  localparam logic [6:0] VLAN_TAG_LEN = 7'd4;
  localparam logic [6:0] IPV4_HDR_LEN = 7'd20;
  localparam logic [6:0] TCP_HDR_LEN  = 7'd20;
  localparam logic [6:0] UDP_HDR_LEN  = 7'd8;

  // Unknown protocols carry no L4 header.
  function automatic logic [6:0] l4_len(input logic [7:0] proto);
    case (proto)
      PROTO_TCP: l4_len = TCP_HDR_LEN;
      PROTO_UDP: l4_len = UDP_HDR_LEN;
      default:   l4_len = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// IPv4 header checksum: 20-bit word accumulator, cleared per build; fold and invert are combinational on the sum.
module ipv4_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_word_vld,
  input  logic [15:0] i_word,
  output logic [15:0] o_csum
);

  logic [19:0] r_acc;
  logic [16:0] w_fold1;
  logic [16:0] w_fold2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 20'h0;
    end else if (i_clr) begin
      r_acc <= 20'h0;
    end else if (i_word_vld) begin
      r_acc <= r_acc + {4'h0, i_word};
    end
  end

  // Ten 16-bit words fit in 20 bits; two end-around carry folds always settle the sum.
  assign w_fold1 = {1'b0, r_acc[15:0]} + {13'h0, r_acc[19:16]};
  assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'h0, w_fold1[16]};
  assign o_csum  = ~w_fold2[15:0];

endmodule

// File: rtl/packet_deparser.sv
// Builds Ethernet(+802.1Q)/IPv4/TCP|UDP headers from fields and streams them one byte per cycle (valid/ready).
// Define DEPARSER_CSUM_EN to compute the IPv4 header checksum; otherwise the field is zero and streaming starts at once.
module packet_deparser
  import deparser_pkg::*;
#(
  parameter logic [15:0] TCP_WINDOW  = 16'hFFFF,
  parameter bit          IP_FLAGS_DF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        build_start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic        has_vlan,
  input  logic [11:0] vlan_id,
  input  logic [5:0]  dscp,
  input  logic [1:0]  ecn,
  input  logic [7:0]  ttl,
  input  logic [7:0]  ip_proto,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [7:0]  tcp_flags,
  input  logic [15:0] payload_len,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [6:0]  hdr_len,
  output logic        busy,
  output logic        build_done
);

  state_t r_state, w_next;

  logic [47:0] r_dst_mac, r_src_mac;
  logic        r_has_vlan;
  logic [11:0] r_vlan_id;
  logic [7:0]  r_tos, r_ttl, r_proto, r_tcp_flags;
  logic [31:0] r_src_ip, r_dst_ip;
  logic [15:0] r_src_port, r_dst_port;
  logic [15:0] r_total_len, r_udp_len, r_csum;
  logic [6:0]  r_hdr_len;
  logic [5:0]  r_idx;

  logic         w_start, w_xfer;
  logic [6:0]   w_l4_len;
  logic [111:0] w_eth_plain;
  logic [143:0] w_eth_vlan;
  logic [159:0] w_ip, w_l4;
  logic [463:0] w_all, w_shift;

  assign w_start  = (r_state == S_IDLE) && build_start;
  assign w_xfer   = out_valid && out_ready;
  assign w_l4_len = l4_len(ip_proto);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst_mac   <= 48'h0;
      r_src_mac   <= 48'h0;
      r_has_vlan  <= 1'b0;
      r_vlan_id   <= 12'h0;
      r_tos       <= 8'h0;
      r_ttl       <= 8'h0;
      r_proto     <= 8'h0;
      r_tcp_flags <= 8'h0;
      r_src_ip    <= 32'h0;
      r_dst_ip    <= 32'h0;
      r_src_port  <= 16'h0;
      r_dst_port  <= 16'h0;
      r_total_len <= 16'h0;
      r_udp_len   <= 16'h0;
      r_hdr_len   <= 7'h0;
    end else if (w_start) begin
      r_dst_mac   <= dst_mac;
      r_src_mac   <= src_mac;
      r_has_vlan  <= has_vlan;
      r_vlan_id   <= vlan_id;
      r_tos       <= {dscp, ecn};
      r_ttl       <= ttl;
      r_proto     <= ip_proto;
      r_tcp_flags <= tcp_flags;
      r_src_ip    <= src_ip;
      r_dst_ip    <= dst_ip;
      r_src_port  <= src_port;
      r_dst_port  <= dst_port;
      r_total_len <= {9'h0, IPV4_HDR_LEN} + {9'h0, w_l4_len} + payload_len;
      r_udp_len   <= {9'h0, UDP_HDR_LEN} + payload_len;
      r_hdr_len   <= ETH_HDR_LEN + (has_vlan ? VLAN_TAG_LEN : 7'd0) + IPV4_HDR_LEN + w_l4_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 6'h0;
    end else if (w_start) begin
      r_idx <= 6'h0;
    end else if (w_xfer) begin
      r_idx <= r_idx + 6'd1;
    end
  end

`ifdef DEPARSER_CSUM_EN
  logic [3:0]  r_widx;
  logic [15:0] w_word, w_csum_fold;

  always_comb begin
    w_word = 16'h0;
    case (r_widx)
      4'd0:    w_word = {8'h45, r_tos};
      4'd1:    w_word = r_total_len;
      4'd3:    w_word = {1'b0, IP_FLAGS_DF, 14'h0};
      4'd4:    w_word = {r_ttl, r_proto};
      4'd6:    w_word = r_src_ip[31:16];
      4'd7:    w_word = r_src_ip[15:0];
      4'd8:    w_word = r_dst_ip[31:16];
      4'd9:    w_word = r_dst_ip[15:0];
      default: w_word = 16'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx <= 4'h0;
    end else if (w_start) begin
      r_widx <= 4'h0;
    end else if (r_state == S_CSUM) begin
      r_widx <= r_widx + 4'd1;
    end
  end

  ipv4_csum_acc u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_start),
    .i_word_vld (r_state == S_CSUM),
    .i_word     (w_word),
    .o_csum     (w_csum_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 16'h0;
    end else if (w_start) begin
      r_csum <= 16'h0;
    end else if (r_state == S_FOLD) begin
      r_csum <= w_csum_fold;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 16'h0;
    end else if (w_start) begin
      r_csum <= 16'h0;
    end
  end
`endif

  // Whole header as one vector, left-aligned so byte index 0 is always the top byte.
  assign w_eth_plain = {r_dst_mac, r_src_mac, ETH_TYPE_IPV4};
  assign w_eth_vlan  = {r_dst_mac, r_src_mac, TPID_VLAN, 4'h0, r_vlan_id, ETH_TYPE_IPV4};
  assign w_ip = {8'h45, r_tos, r_total_len, 16'h0, 1'b0, IP_FLAGS_DF, 14'h0,
                 r_ttl, r_proto, r_csum, r_src_ip, r_dst_ip};

  always_comb begin
    w_l4 = 160'h0;
    if (r_proto == PROTO_TCP) begin
      w_l4 = {r_src_port, r_dst_port, 32'h0, 32'h0, 8'h50, r_tcp_flags, TCP_WINDOW, 16'h0, 16'h0};
    end else if (r_proto == PROTO_UDP) begin
      w_l4 = {r_src_port, r_dst_port, r_udp_len, 16'h0, 96'h0};
    end
  end

  assign w_all   = r_has_vlan ? {w_eth_vlan, w_ip, w_l4} : {w_eth_plain, w_ip, w_l4, 32'h0};
  assign w_shift = w_all << {r_idx, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    build_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (build_start) begin
`ifdef DEPARSER_CSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_STREAM;
`endif
        end
      end
`ifdef DEPARSER_CSUM_EN
      S_CSUM: begin
        busy = 1'b1;
        if (r_widx == 4'd9) w_next = S_FOLD;
      end
      S_FOLD: begin
        busy   = 1'b1;
        w_next = S_STREAM;
      end
`endif
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && ({1'b0, r_idx} == r_hdr_len - 7'd1)) w_next = S_DONE;
      end
      S_DONE: begin
        build_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_data = out_valid ? w_shift[463:456] : 8'h0;
  assign out_last = out_valid && ({1'b0, r_idx} == r_hdr_len - 7'd1);
  assign hdr_len  = r_hdr_len;

endmodule

// File: tb/tb_packet_deparser.sv
// Bench for packet_deparser: table vectors, stall/pulse/reset sequences and random builds against a byte-level model.
module tb_packet_deparser;

  logic        clk, rst_n, build_start;
  logic [47:0] dst_mac, src_mac;
  logic        has_vlan;
  logic [11:0] vlan_id;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [7:0]  ttl, ip_proto, tcp_flags;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, payload_len;
  logic        out_ready, out_valid, out_last, busy, build_done;
  logic [7:0]  out_data;
  logic [6:0]  hdr_len;

  packet_deparser dut (
    .clk(clk), .rst_n(rst_n), .build_start(build_start),
    .dst_mac(dst_mac), .src_mac(src_mac), .has_vlan(has_vlan), .vlan_id(vlan_id),
    .dscp(dscp), .ecn(ecn), .ttl(ttl), .ip_proto(ip_proto),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .tcp_flags(tcp_flags), .payload_len(payload_len), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .hdr_len(hdr_len), .busy(busy), .build_done(build_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DEPARSER_CSUM_EN
  localparam int          EXP_LAT  = 11;
  localparam logic [15:0] CSUM_TCP = 16'h26CE;
`else
  localparam int          EXP_LAT  = 0;
  localparam logic [15:0] CSUM_TCP = 16'h0000;
`endif

  typedef struct {
    logic [47:0] dst, src;
    logic        vlan;
    logic [11:0] vid;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl, proto, flags;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp, plen;
  } fld_t;

  typedef struct {
    fld_t             f;
    int               exp_len;
    logic [3:0][6:0]  ci;
    logic [3:0][15:0] cv;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_n(input logic [63:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Reference header built byte by byte from the field rules.
  task automatic model(input fld_t f);
    logic [7:0]  ip [20];
    logic [31:0] s;
    logic [15:0] tl, ul, cs;
    int          l4;
    exp_q.delete();
    push_n({16'h0, f.dst}, 6);
    push_n({16'h0, f.src}, 6);
    if (f.vlan) push_n({32'h0, 16'h8100, 4'h0, f.vid}, 4);
    push_n(64'h0800, 2);
    l4 = (f.proto == 8'd6) ? 20 : (f.proto == 8'd17) ? 8 : 0;
    tl = 16'(20 + l4 + int'(f.plen));
    ul = 16'(8 + int'(f.plen));
    ip = '{8'h45, {f.dscp, f.ecn}, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
           f.ttl, f.proto, 8'h00, 8'h00, f.sip[31:24], f.sip[23:16], f.sip[15:8], f.sip[7:0],
           f.dip[31:24], f.dip[23:16], f.dip[15:8], f.dip[7:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, ip[2*i], ip[2*i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
`ifdef DEPARSER_CSUM_EN
    ip[10] = cs[15:8];
    ip[11] = cs[7:0];
`endif
    for (int i = 0; i < 20; i++) exp_q.push_back(ip[i]);
    if (l4 == 20) begin
      push_n({f.sp, f.dp, 32'h0}, 8);
      push_n(64'h0, 4);
      push_n({40'h0, 8'h50, f.flags, 16'hFFFF}, 4);
      push_n(64'h0, 4);
    end else if (l4 == 8) begin
      push_n({f.sp, f.dp, ul, 16'h0}, 8);
    end
  endtask

  task automatic set_fields(input fld_t f);
    dst_mac = f.dst; src_mac = f.src; has_vlan = f.vlan; vlan_id = f.vid;
    dscp = f.dscp; ecn = f.ecn; ttl = f.ttl; ip_proto = f.proto;
    src_ip = f.sip; dst_ip = f.dip; src_port = f.sp; dst_port = f.dp;
    tcp_flags = f.flags; payload_len = f.plen;
  endtask

  // One complete build; optional random stalls and an ignored mid-stream start pulse.
  task automatic do_build(input fld_t f, input bit stall, input int pulse_at, input string tag);
    int         first_c, nbad;
    bit         done, prev_stall, hold_bad, pulsed, r, seen_busy;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [6:0] seen_len;
    model(f);
    set_fields(f);
    build_start = 1'b1;
    out_ready   = 1'b0;
    @(negedge clk);
    build_start = 1'b0;
    got_q.delete();
    first_c = -1; done = 0; prev_stall = 0; hold_bad = 0; pulsed = 0;
    seen_len = 7'h0; seen_busy = 0; prev_data = 8'h0; prev_last = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid && first_c < 0) begin
        first_c   = c;
        seen_len  = hdr_len;
        seen_busy = busy;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) hold_bad = 1;
      r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      build_start = (pulse_at >= 0) && !pulsed && out_valid && (got_q.size() == pulse_at);
      if (build_start) pulsed = 1;
      out_ready = r;
      if (out_valid && r) begin
        got_q.push_back(out_data);
        if (out_last) done = 1;
      end
      prev_stall = out_valid && !r;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    @(negedge clk);
    build_start = 1'b0;
    out_ready   = 1'b0;
    chk({tag, " completed"}, done, 1);
    chk({tag, " build_done pulse"}, {build_done, busy, out_valid}, 3'b100);
    @(negedge clk);
    chk({tag, " idle after done"}, {build_done, busy, out_valid}, 3'b000);
    chk({tag, " first valid latency"}, first_c, EXP_LAT);
    chk({tag, " busy while streaming"}, seen_busy, 1);
    chk({tag, " hdr_len"}, seen_len, exp_q.size());
    chk({tag, " byte count"}, got_q.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    chk({tag, " bytes mismatching model"}, nbad, 0);
    if (stall) chk({tag, " held while stalled"}, hold_bad, 0);
  endtask

  task automatic chk16(input string tag, input int idx, input logic [15:0] v);
    logic [15:0] a;
    a = (idx + 1 < got_q.size()) ? {got_q[idx], got_q[idx+1]} : 16'hxxxx;
    chk($sformatf("%s bytes@%0d", tag, idx), a, v);
  endtask

  vec_t vt[5];
  fld_t f_tcp, fr;
  int   n;

  initial begin
    rst_n = 1'b0; build_start = 1'b0; out_ready = 1'b0;
    set_fields('{default: '0});

    f_tcp = '{dst: 48'h001122334455, src: 48'h66778899AABB, vlan: 1'b0, vid: 12'h0,
              dscp: 6'h0, ecn: 2'h0, ttl: 8'd64, proto: 8'd6, flags: 8'h02,
              sip: 32'h0A000001, dip: 32'h0A000002, sp: 16'h1234, dp: 16'h0050, plen: 16'd0};
    vt[0].f = f_tcp; vt[0].exp_len = 54;
    vt[0].ci = {7'd48, 7'd46, 7'd24, 7'd16}; vt[0].cv = {16'hFFFF, 16'h5002, CSUM_TCP, 16'h0028};
    vt[1].f = f_tcp; vt[1].f.vlan = 1'b1; vt[1].f.vid = 12'h123; vt[1].f.proto = 8'd17;
    vt[1].f.plen = 16'd100; vt[1].f.dscp = 6'h2E; vt[1].f.ecn = 2'h1; vt[1].exp_len = 46;
    vt[1].ci = {7'd42, 7'd20, 7'd14, 7'd12}; vt[1].cv = {16'h006C, 16'h0080, 16'h0123, 16'h8100};
    vt[2].f = f_tcp; vt[2].f.proto = 8'd1; vt[2].f.plen = 16'd5; vt[2].exp_len = 34;
    vt[2].ci = {7'd22, 7'd20, 7'd16, 7'd12}; vt[2].cv = {16'h4001, 16'h4000, 16'h0019, 16'h0800};
    vt[3].f = f_tcp; vt[3].f.proto = 8'd17; vt[3].f.plen = 16'hFFFF; vt[3].f.sp = 16'hABCD;
    vt[3].f.dp = 16'h0035; vt[3].exp_len = 42;
    vt[3].ci = {7'd36, 7'd34, 7'd38, 7'd16}; vt[3].cv = {16'h0035, 16'hABCD, 16'h0007, 16'h001B};
    vt[4].f = f_tcp; vt[4].f.vlan = 1'b1; vt[4].f.vid = 12'hFFF; vt[4].f.plen = 16'd10; vt[4].exp_len = 58;
    vt[4].ci = {7'd56, 7'd20, 7'd16, 7'd14}; vt[4].cv = {16'h0000, 16'h0032, 16'h0800, 16'h0FFF};

    #2;
    chk("reset outputs", {out_valid, out_last, build_done, busy, out_data, hdr_len},
        {4'b0000, 8'h00, 7'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_build(vt[i].f, 1'b0, -1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table hdr_len", i), got_q.size(), vt[i].exp_len);
      for (int k = 0; k < 4; k++) chk16($sformatf("vec%0d", i), int'(vt[i].ci[k]), vt[i].cv[k]);
      if (i == 0) ref_q = got_q;
    end

    do_build(f_tcp, 1'b1, -1, "stall");
    n = 0;
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) if (got_q[i] !== ref_q[i]) n++;
    chk("stall vs no-stall bytes", {got_q.size(), n}, {ref_q.size(), 32'd0});

    do_build(vt[1].f, 1'b0, 10, "midpulse");

    set_fields(f_tcp);
    build_start = 1'b1;
    @(negedge clk);
    build_start = 1'b0;
    out_ready   = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid) begin
        if (n == 20) break;
        n++;
      end
      @(negedge clk);
    end
    chk("reached byte 20", {out_valid, out_data}, {1'b1, ref_q[20]});
    rst_n = 1'b0;
    #1;
    chk("mid-build reset outputs", {out_valid, out_last, build_done, busy, out_data, hdr_len},
        {4'b0000, 8'h00, 7'h00});
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    do_build(f_tcp, 1'b0, -1, "post-reset");

    for (int i = 0; i < 8; i++) begin
      fr = '{dst: {$urandom, $urandom}, src: {$urandom, $urandom}, vlan: 1'($urandom),
             vid: 12'($urandom), dscp: 6'($urandom), ecn: 2'($urandom), ttl: 8'($urandom),
             proto: 8'($urandom), flags: 8'($urandom), sip: $urandom, dip: $urandom,
             sp: 16'($urandom), dp: 16'($urandom), plen: 16'($urandom)};
      if (i % 3 == 0) fr.proto = 8'd6;
      else if (i % 3 == 1) fr.proto = 8'd17;
      do_build(fr, 1'($urandom), -1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
